// File: rtl/counter_pkg.sv
// Shared encodings for the LED counter command scheduler: command opcodes, FSM states,
// button indices and the priority helpers used by the arbiter.
package counter_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_CLR  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDelay,
    StRepeat,
    StWaitRel
  } sched_state_e;

  localparam int unsigned BTN_UP   = 0;
  localparam int unsigned BTN_DOWN = 1;
  localparam int unsigned BTN_CLR  = 2;

  // Opcode encodings are ordered so that a larger value means a higher priority.
  function automatic cmd_op_e prio_op(input logic [2:0] btn);
    if (btn[BTN_CLR]) begin
      return OP_CLR;
    end else if (btn[BTN_DOWN]) begin
      return OP_DOWN;
    end else if (btn[BTN_UP]) begin
      return OP_UP;
    end
    return OP_NONE;
  endfunction

  function automatic logic [2:0] op_mask(input cmd_op_e op);
    logic [2:0] mask;
    mask = 3'b000;
    unique case (op)
      OP_UP:   mask[BTN_UP]   = 1'b1;
      OP_DOWN: mask[BTN_DOWN] = 1'b1;
      OP_CLR:  mask[BTN_CLR]  = 1'b1;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button input path: 2-FF synchronizer followed by a stable-level debouncer.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned TMR_W     = 26
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [TMR_W-1:0] CntMax = TMR_W'(DB_CYCLES - 32'd1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [TMR_W-1:0] r_cnt;

  // The level flips on the DB_CYCLES-th consecutive cycle of disagreement; agreement restarts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt >= CntMax) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + TMR_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/counter_cmd_sched.sv
// Button command scheduler: debounces three buttons, arbitrates clear > down > up and offers one
// command per press plus auto-repeat over a valid/ready handshake.
module counter_cmd_sched
  import counter_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 1_000_000,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned TMR_W         = 26
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic [2:0] BUTTONS,
  output logic       CMD_VALID,
  output logic [1:0] CMD_OP,
  input  logic       CMD_READY,
  output logic [2:0] BTN_STATE
);

  // Loads are offset by two so accepted commands are exactly DELAY/PERIOD cycles apart:
  // one cycle is spent entering the wait state and one re-entering ISSUE.
  localparam logic [TMR_W-1:0] DelayLoad =
      TMR_W'((REPEAT_DELAY >= 32'd2) ? (REPEAT_DELAY - 32'd2) : 32'd0);
  localparam logic [TMR_W-1:0] PeriodLoad =
      TMR_W'((REPEAT_PERIOD >= 32'd2) ? (REPEAT_PERIOD - 32'd2) : 32'd0);

  logic [2:0]       w_db;
  logic [2:0]       w_rise;
  logic             w_held;
  cmd_op_e          w_top;

  sched_state_e     r_state, w_state_nxt;
  cmd_op_e          r_op, w_op_nxt;
  logic             r_first, w_first_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [2:0]       r_db_prev;
  logic             r_valid;
  cmd_op_e          r_cmd_op;

  for (genvar gi = 0; gi < 3; gi++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .TMR_W    (TMR_W)
    ) u_db (
      .i_clk  (CLOCK),
      .i_rst_n(RESET_N),
      .i_raw  (BUTTONS[gi]),
      .o_level(w_db[gi])
    );
  end

  assign w_rise = w_db & ~r_db_prev;
  assign w_held = |(w_db & op_mask(r_op));
  assign w_top  = prio_op(w_db);

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_first_nxt = r_first;
    w_timer_nxt = r_timer;
    unique case (r_state)
      StIdle: begin
        if (|w_rise) begin
          w_state_nxt = StIssue;
          w_op_nxt    = w_top;
          w_first_nxt = 1'b1;
        end
      end
      StIssue: begin
        if (CMD_READY) begin
          if (r_op == OP_CLR) begin
            w_state_nxt = StWaitRel;
          end else if (!w_held) begin
            w_state_nxt = StIdle;
          end else if (r_first) begin
            w_state_nxt = StDelay;
            w_timer_nxt = DelayLoad;
          end else begin
            w_state_nxt = StRepeat;
            w_timer_nxt = PeriodLoad;
          end
        end
      end
      StDelay, StRepeat: begin
        if (!w_held) begin
          w_state_nxt = StIdle;
        end else if (w_top > r_op) begin
          // Higher-priority button takes ownership as a fresh press.
          w_state_nxt = StIssue;
          w_op_nxt    = w_top;
          w_first_nxt = 1'b1;
        end else if (r_timer == '0) begin
          w_state_nxt = StIssue;
          w_first_nxt = 1'b0;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      StWaitRel: begin
        if (w_db == 3'b000) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= StIdle;
      r_op      <= OP_NONE;
      r_first   <= 1'b0;
      r_timer   <= '0;
      r_db_prev <= 3'b000;
      r_valid   <= 1'b0;
      r_cmd_op  <= OP_NONE;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_first   <= w_first_nxt;
      r_timer   <= w_timer_nxt;
      r_db_prev <= w_db;
      r_valid   <= (w_state_nxt == StIssue);
      r_cmd_op  <= (w_state_nxt == StIssue) ? w_op_nxt : OP_NONE;
    end
  end

  assign CMD_VALID = r_valid;
  assign CMD_OP    = r_cmd_op;
  assign BTN_STATE = w_db;

endmodule

// File: tb/tb_counter_cmd_sched.sv
// Self-checking bench for counter_cmd_sched with short debounce/repeat parameters.
module tb_counter_cmd_sched;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk;
  logic       rst_n;
  logic [2:0] btn;
  logic       valid;
  logic [1:0] op;
  logic       ready;
  logic [2:0] bstate;

  int cyc;
  int n_checks;
  int n_fail;

  typedef struct {
    int         t;
    logic [1:0] op;
  } xfer_t;

  xfer_t got[$];
  xfer_t exp_q[$];

  counter_cmd_sched #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .TMR_W        (8)
  ) dut (
    .CLOCK    (clk),
    .RESET_N  (rst_n),
    .BUTTONS  (btn),
    .CMD_VALID(valid),
    .CMD_OP   (op),
    .CMD_READY(ready),
    .BTN_STATE(bstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    assert (got_v === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s got=%0d expected=%0d", tag, got_v, exp_v);
    end
  endtask

  // Log every transfer; OP must read 00 whenever nothing is offered.
  always @(negedge clk) begin
    xfer_t x;
    if (valid === 1'b1 && ready === 1'b1) begin
      x.t  = cyc;
      x.op = op;
      got.push_back(x);
    end
    if (valid !== 1'b1) check("idle_op_zero", 32'(op), 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int t, input logic [1:0] o);
    xfer_t x;
    x.t  = t;
    x.op = o;
    exp_q.push_back(x);
  endtask

  // Single button held from cycle tp to tr: first command when the debounced level has risen,
  // repeats after RD then every RP while the debounced level is still high.
  task automatic model_hold(input int tp, input int tr, input logic [1:0] o);
    int t;
    int fall;
    if (tr - tp < DB) return;
    t    = tp + DB + 3;
    fall = tr + DB + 2;
    push_exp(t, o);
    if (o == 2'b11) return;
    t += RD;
    while (t <= fall) begin
      push_exp(t, o);
      t += RP;
    end
  endtask

  task automatic cmp_q(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check({tag, "_time"}, got[i].t, exp_q[i].t);
      check({tag, "_op"}, 32'(got[i].op), 32'(exp_q[i].op));
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int tp;
    int tr;
    int tc;
    int r;
    int t;
    int hold;
    int sel;
    logic [1:0] o;
    logic bounced;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    btn      = 3'b000;
    ready    = 1'b1;
    tick(3);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_op", 32'(op), 32'd0);
    check("reset_btn_state", 32'(bstate), 32'd0);
    rst_n = 1'b1;
    tick(2);
    got.delete();

    // Short pulses, up to DB-1 cycles each, must never change the debounced level.
    bounced = 1'b0;
    btn = 3'b001;
    tick(3);
    btn = 3'b000;
    repeat (4) begin
      tick($urandom_range(1, 2));
      btn = 3'b001;
      repeat ($urandom_range(1, DB - 1)) begin
        tick(1);
        if (bstate !== 3'b000) bounced = 1'b1;
      end
      btn = 3'b000;
    end
    repeat (12) begin
      tick(1);
      if (bstate !== 3'b000) bounced = 1'b1;
    end
    check("bounce_btn_state", 32'(bounced), 32'd0);
    cmp_q("bounce");

    // Single short press of up.
    tp  = cyc;
    btn = 3'b001;
    tick(DB + 1);
    check("press_before_rise", 32'(bstate), 32'd0);
    tick(1);
    check("press_rise", 32'(bstate), 32'd1);
    tick(4);
    tr  = cyc;
    btn = 3'b000;
    tick(20);
    model_hold(tp, tr, 2'b01);
    cmp_q("single_up");

    // Long hold of down: first issue, delayed repeat, periodic repeats.
    tp  = cyc;
    btn = 3'b010;
    tick(60);
    tr  = cyc;
    btn = 3'b000;
    tick(30);
    model_hold(tp, tr, 2'b10);
    cmp_q("hold_down");

    // Random single-button holds.
    repeat (4) begin
      sel  = $urandom_range(0, 2);
      hold = $urandom_range(30, 80);
      o    = 2'(sel + 1);
      tp   = cyc;
      btn  = 3'b001 << sel;
      tick(hold);
      tr   = cyc;
      btn  = 3'b000;
      tick(30);
      model_hold(tp, tr, o);
      cmp_q("rand_hold");
    end

    // Back-pressure: offer must hold steady until accepted.
    ready = 1'b0;
    tp    = cyc;
    btn   = 3'b001;
    tick(DB + 3);
    for (int i = 0; i < 15; i++) begin
      check("stall_valid", 32'(valid), 32'd1);
      check("stall_op", 32'(op), 32'd1);
      tick(1);
    end
    ready = 1'b1;
    btn   = 3'b000;
    tick(20);
    push_exp(tp + DB + 3 + 15, 2'b01);
    cmp_q("stall");

    // Up held into repeats, then clear preempts and never repeats.
    tp  = cyc;
    btn = 3'b001;
    tick($urandom_range(25, 45));
    tc  = cyc;
    btn = 3'b101;
    tick(40);
    check("both_held_state", 32'(bstate), 32'd5);
    btn = 3'b001;
    tick(15);
    btn = 3'b000;
    tick(20);
    r = tc + DB + 2;
    t = tp + DB + 3;
    push_exp(t, 2'b01);
    t += RD;
    while (t <= r) begin
      push_exp(t, 2'b01);
      t += RP;
    end
    push_exp((exp_q[exp_q.size() - 1].t == r) ? r + 2 : r + 1, 2'b11);
    cmp_q("clear_preempt");

    // Simultaneous down and up from idle: only down is issued.
    tp  = cyc;
    btn = 3'b011;
    tick(10);
    btn = 3'b000;
    tick(20);
    push_exp(tp + DB + 3, 2'b10);
    cmp_q("dual_press");

    // Reset in the middle of an unaccepted offer.
    ready = 1'b0;
    btn   = 3'b001;
    tick(DB + 4);
    check("pre_reset_valid", 32'(valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", 32'(valid), 32'd0);
    check("mid_reset_op", 32'(op), 32'd0);
    check("mid_reset_btn_state", 32'(bstate), 32'd0);
    btn = 3'b000;
    tick(3);
    rst_n = 1'b1;
    ready = 1'b1;
    tick(30);
    cmp_q("post_reset_quiet");
    tp  = cyc;
    btn = 3'b001;
    tick(10);
    btn = 3'b000;
    tick(20);
    push_exp(tp + DB + 3, 2'b01);
    cmp_q("post_reset_press");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
